alu_digit_serial: RTL and testbench
===================================

ALU_DIGIT_SERIAL -- requirements
Module: alu_digit_serial

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter SLICE_W, default 8: bits processed per cycle; WIDTH % SLICE_W == 0 SHALL hold, else elaboration error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; accepted only when ready=1.
REQ-006 a, b  input  WIDTH each  operands, sampled on the accepting edge only.
REQ-007 f  input  3  op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; other codes are "unsupported".
REQ-008 ready  output  1  high in IDLE only.
REQ-009 done  output  1  single-cycle pulse marking r/cout valid.
REQ-010 r  output  WIDTH  result; holds its value until the next done.
REQ-011 cout  output  1  carry out of the MSB slice.
REQ-012 zero, ovf  output  1 each  result flags (present only with ALU_FLAGS_EN).

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start&ready, RUN->DONE after N=WIDTH/SLICE_W slice cycles, DONE->IDLE unconditionally after one cycle.
REQ-014 On acceptance, the block SHALL latch a, b and f, clear the slice counter, and initialise the carry register to 1 for SUB/SLT and to 0 otherwise.
REQ-015 Each RUN cycle SHALL process slice k (bits k*SLICE_W..k*SLICE_W+SLICE_W-1, LSB slice first): AND/OR bitwise; ADD a+b+c; SUB/SLT a+~b+c; the slice carry-out is registered into the carry register for slice k+1.
REQ-016 done SHALL be high in the DONE cycle, i.e. exactly N cycles after the accepting edge (N=4 at defaults); ready SHALL be low from the accepting edge until DONE->IDLE.
REQ-017 start while ready=0 SHALL be ignored without side effects; a and b changing during RUN SHALL NOT affect the result.
REQ-018 SLT SHALL give r = {WIDTH-1 zeros, sign XOR signed_overflow} of a-b; cout SHALL equal the subtract carry.
REQ-019 AND/OR SHALL give cout=0; unsupported f SHALL give r=0, cout=0 with the normal latency.
REQ-020 The final r and cout SHALL update on the RUN->DONE edge only; intermediate slices SHALL NOT be visible on r.

Reset
REQ-021 When rst_n=0, the block SHALL immediately enter IDLE and force ready=1, done=0, r=0, cout=0, zero=0, ovf=0, counter=0, carry=0.
REQ-022 Reset during RUN SHALL abandon the operation with no done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-023 Macro ALU_FLAGS_EN defined: zero=(r==0) and ovf=signed overflow of ADD/SUB (0 for other ops) are registered alongside r and valid with done.
REQ-024 Macro ALU_FLAGS_EN undefined: the zero and ovf ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 Package alu_pkg SHALL hold the op-code localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT) and the FSM state enum.
REQ-026 The SLICE_W-bit combinational datapath (inputs a, b, cin, op; outputs r, cout, msb carry-in for overflow) SHALL be a sub-module alu_slice_n, instantiated once and reused every RUN cycle.

Verification (WIDTH=32, SLICE_W=8 unless stated)
REQ-027 ADD a=0xFFFFFFFF, b=0x00000001 -> r=0x00000000, cout=1, done exactly 4 cycles after the accepting edge, zero=1, ovf=0.
REQ-028 SUB a=5, b=7 -> r=0xFFFFFFFE, cout=0; SLT a=0xFFFFFFFF, b=1 -> r=0x00000001; SLT a=1, b=0xFFFFFFFF -> r=0.
REQ-029 ADD a=0x7FFFFFFF, b=1 -> r=0x80000000, ovf=1; AND a=0xF0F0F0F0, b=0xFF00FF00 -> r=0xF000F000, cout=0.
REQ-030 start pulsed with new operands during RUN -> ignored; the first result is unchanged; exactly one done pulse.
REQ-031 rst_n low at the 2nd RUN cycle -> no done pulse, outputs at reset values; the next ADD 3+4 -> r=7.
REQ-032 Rerun with WIDTH=16, SLICE_W=1 and with SLICE_W=WIDTH: ADD 0xFFFF+1 -> r=0, cout=1, latencies 16 and 1.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the digit-serial ALU: operation codes, the control
// FSM state type and a helper that identifies subtract-type operations.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // SUB and SLT both compute a + ~b + 1, so they share the inverted
    // operand and the carry-in of one on the first slice.
    function automatic logic isSubtract(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_slice_n.sv
// ---------------------------------------------------------------------------
// alu_slice_n
// Combinational SLICE_W-bit ALU slice, reused every cycle by the serial
// controller.
// Ports:
//   i_a, i_b   : operand slices
//   i_cin      : carry into bit 0 of the slice
//   i_op       : operation code (alu_pkg OP_*)
//   o_r        : slice result (zero for unsupported codes)
//   o_cout     : carry out of the slice (zero for logic/unsupported ops)
//   o_cmsb     : carry into the slice MSB, used for signed overflow
// ---------------------------------------------------------------------------
module alu_slice_n
    import alu_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    input  logic [2:0]         i_op,
    output logic [SLICE_W-1:0] o_r,
    output logic               o_cout,
    output logic               o_cmsb
);

    logic [SLICE_W-1:0] w_bx;
    logic [SLICE_W:0]   w_sum;

    // The carry into the MSB is recovered from the MSB sum bit, which keeps
    // the slice valid down to SLICE_W = 1.
    always_comb begin
        w_bx   = isSubtract(i_op) ? ~i_b : i_b;
        w_sum  = {1'b0, i_a} + {1'b0, w_bx} + {{SLICE_W{1'b0}}, i_cin};
        o_cmsb = w_sum[SLICE_W-1] ^ i_a[SLICE_W-1] ^ w_bx[SLICE_W-1];
        o_r    = '0;
        o_cout = 1'b0;
        case (i_op)
            OP_AND: o_r = i_a & i_b;
            OP_OR:  o_r = i_a | i_b;
            OP_ADD, OP_SUB, OP_SLT: begin
                o_r    = w_sum[SLICE_W-1:0];
                o_cout = w_sum[SLICE_W];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_digit_serial.sv
// ---------------------------------------------------------------------------
// alu_digit_serial
// Digit-serial ALU: processes SLICE_W bits per cycle, LSB slice first, and
// presents the full result WIDTH/SLICE_W cycles after the accepting edge.
// Optional feature macro: ALU_FLAGS_EN adds the registered zero/ovf flags.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted only while ready is high
//   a, b, f    : operands and op code, sampled on the accepting edge
//   ready      : high in IDLE only
//   done       : one-cycle pulse when r/cout are valid
//   r, cout    : result and carry out of the MSB slice
//   zero, ovf  : result flags (ALU_FLAGS_EN only)
// ---------------------------------------------------------------------------
module alu_digit_serial
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             cout
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (WIDTH % SLICE_W != 0) begin : gBadSlice
            $error("alu_digit_serial: WIDTH must be a multiple of SLICE_W");
        end
    endgenerate

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_acc;

    logic [SLICE_W-1:0] w_aSlice;
    logic [SLICE_W-1:0] w_bSlice;
    logic [SLICE_W-1:0] w_sliceR;
    logic               w_sliceCout;
    logic               w_sliceCmsb;
    logic               w_lastSlice;
    logic               w_signedOvf;
    logic [WIDTH-1:0]   w_accNext;
    logic [WIDTH-1:0]   w_finalR;

    assign w_aSlice = r_a[int'(r_cnt) * SLICE_W +: SLICE_W];
    assign w_bSlice = r_b[int'(r_cnt) * SLICE_W +: SLICE_W];

    alu_slice_n #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .i_a    (w_aSlice),
        .i_b    (w_bSlice),
        .i_cin  (r_carry),
        .i_op   (r_op),
        .o_r    (w_sliceR),
        .o_cout (w_sliceCout),
        .o_cmsb (w_sliceCmsb)
    );

    // Partial results collect in r_acc; r itself only changes on the final
    // slice so intermediate slices never show on the output.
    always_comb begin
        w_lastSlice = (r_state == ST_RUN) && (r_cnt == LAST);
        w_signedOvf = w_sliceCmsb ^ w_sliceCout;
        w_accNext   = r_acc;
        w_accNext[int'(r_cnt) * SLICE_W +: SLICE_W] = w_sliceR;
        if (r_op == OP_SLT) begin
            w_finalR    = '0;
            w_finalR[0] = w_accNext[WIDTH-1] ^ w_signedOvf;
        end else begin
            w_finalR = w_accNext;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (start)            w_nextState = ST_RUN;
            ST_RUN:  if (r_cnt == LAST)    w_nextState = ST_DONE;
            ST_DONE:                       w_nextState = ST_IDLE;
            default:                       w_nextState = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (r_state == ST_IDLE);
        done  = (r_state == ST_DONE);
    end

    // Datapath: operand capture on acceptance, one slice per RUN cycle, the
    // carry register chaining slice k into slice k+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= OP_AND;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_acc   <= '0;
            r       <= '0;
            cout    <= 1'b0;
`ifdef ALU_FLAGS_EN
            zero    <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else if (r_state == ST_IDLE && start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= f;
            r_cnt   <= '0;
            r_carry <= isSubtract(f);
            r_acc   <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc   <= w_accNext;
            r_carry <= w_sliceCout;
            if (w_lastSlice) begin
                r_cnt <= '0;
                r     <= w_finalR;
                cout  <= w_sliceCout;
`ifdef ALU_FLAGS_EN
                zero  <= (w_finalR == '0);
                ovf   <= ((r_op == OP_ADD) || (r_op == OP_SUB)) ? w_signedOvf : 1'b0;
`endif
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_digit_serial.sv
// ---------------------------------------------------------------------------
// tb_alu_digit_serial
// Self-checking bench for alu_digit_serial: directed vector table, random
// operations against an arithmetic reference model, mid-run start and reset
// sequences, and two extra instances with WIDTH=16 (SLICE_W=1 and 16).
// ---------------------------------------------------------------------------
module tb_alu_digit_serial;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        ready;
    logic        done;
    logic [31:0] r;
    logic        cout;

    logic        startS;
    logic        startW;
    logic [15:0] aS;
    logic [15:0] bS;
    logic [2:0]  fS;
    logic        readyS, doneS, coutS;
    logic        readyW, doneW, coutW;
    logic [15:0] rS;
    logic [15:0] rW;

`ifdef ALU_FLAGS_EN
    logic zero, ovf, zeroS, ovfS, zeroW, ovfW;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;
    int doneCount   = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expR;
        logic        expCout;
        logic        expZero;
        logic        expOvf;
    } vec_t;

    vec_t vecs[10];

    alu_digit_serial #(.WIDTH(32), .SLICE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .f(f),
        .ready(ready), .done(done), .r(r), .cout(cout)
`ifdef ALU_FLAGS_EN
        , .zero(zero), .ovf(ovf)
`endif
    );

    alu_digit_serial #(.WIDTH(16), .SLICE_W(1)) dutS (
        .clk(clk), .rst_n(rst_n), .start(startS), .a(aS), .b(bS), .f(fS),
        .ready(readyS), .done(doneS), .r(rS), .cout(coutS)
`ifdef ALU_FLAGS_EN
        , .zero(zeroS), .ovf(ovfS)
`endif
    );

    alu_digit_serial #(.WIDTH(16), .SLICE_W(16)) dutW (
        .clk(clk), .rst_n(rst_n), .start(startW), .a(aS), .b(bS), .f(fS),
        .ready(readyW), .done(doneW), .r(rW), .cout(coutW)
`ifdef ALU_FLAGS_EN
        , .zero(zeroW), .ovf(ovfW)
`endif
    );

    // Free-running clock and a cycle counter used to measure latency.
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Count done pulses mid-cycle so every DONE cycle is seen exactly once.
    always @(negedge clk) if (done) doneCount++;

    // Reference model written straight from the operation definitions.
    function automatic void refAlu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rr, output logic cc,
                                   output logic zz, output logic oo);
        logic [32:0] t;
        rr = 32'h0; cc = 1'b0; oo = 1'b0;
        case (op)
            3'b000: rr = x & y;
            3'b001: rr = x | y;
            3'b010: begin
                t  = {1'b0, x} + {1'b0, y};
                rr = t[31:0]; cc = t[32];
                oo = ($signed(x) + $signed(y)) != ($signed({x[31], x}) + $signed({y[31], y}));
            end
            3'b110: begin
                rr = x - y; cc = (x >= y);
                oo = (x[31] != y[31]) && (rr[31] != x[31]);
            end
            3'b111: begin
                rr = ($signed(x) < $signed(y)) ? 32'h1 : 32'h0;
                cc = (x >= y);
            end
            default: ;
        endcase
        zz = (rr == 32'h0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Run one operation on the 32-bit instance. A second start with junk
    // operands is pulsed during RUN; it must be ignored and r must hold.
    task automatic applyStimulus(input logic [2:0] opF, input logic [31:0] opA, input logic [31:0] opB,
                                 output logic [31:0] gotR, output logic gotCout,
                                 output logic gotZero, output logic gotOvf,
                                 output int latency, output int doneDelta, output bit holdOk);
        int guard;
        int acceptCycle;
        int doneBefore;
        logic [31:0] prevR;
        guard = 0;
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        f = opF; a = opA; b = opB; start = 1'b1;
        prevR      = r;
        doneBefore = doneCount;
        @(posedge clk);
        #1;
        acceptCycle = cycle;
        start  = 1'b0;
        holdOk = !ready;
        @(negedge clk);
        if (r !== prevR) holdOk = 1'b0;
        start = 1'b1; a = $urandom; b = $urandom; f = 3'($urandom_range(0, 7));
        @(negedge clk);
        if (r !== prevR) holdOk = 1'b0;
        start = 1'b0;
        guard = 0;
        while (!done && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        latency = cycle - acceptCycle;
        gotR    = r;
        gotCout = cout;
`ifdef ALU_FLAGS_EN
        gotZero = zero;
        gotOvf  = ovf;
`else
        gotZero = 1'b0;
        gotOvf  = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (done) holdOk = 1'b0;
        doneDelta = doneCount - doneBefore;
    endtask

    task automatic checkOp(input string tag, input logic [2:0] opF, input logic [31:0] opA, input logic [31:0] opB,
                           input logic [31:0] expR, input logic expC, input logic expZ, input logic expO);
        logic [31:0] gotR;
        logic gotC, gotZ, gotO;
        int lat, dd;
        bit hold;
        applyStimulus(opF, opA, opB, gotR, gotC, gotZ, gotO, lat, dd, hold);
        checkOutput({tag, " r"}, gotR, expR);
        checkOutput({tag, " cout"}, {31'b0, gotC}, {31'b0, expC});
        checkOutput({tag, " latency"}, lat, 4);
        checkOutput({tag, " donePulses"}, dd, 1);
        checkOutput({tag, " readyLow/rHold/donePulseWidth"}, {31'b0, hold}, 32'h1);
`ifdef ALU_FLAGS_EN
        checkOutput({tag, " zero"}, {31'b0, gotZ}, {31'b0, expZ});
        checkOutput({tag, " ovf"}, {31'b0, gotO}, {31'b0, expO});
`else
        if (gotZ || gotO || expZ || expO) begin end
`endif
    endtask

    // ADD 0xFFFF + 1 on one of the WIDTH=16 instances.
    task automatic runSmall(input bit wide, output logic [15:0] gotR, output logic gotC, output int lat);
        int guard;
        int acc;
        @(negedge clk);
        aS = 16'hFFFF; bS = 16'h0001; fS = OP_ADD;
        if (wide) startW = 1'b1; else startS = 1'b1;
        @(posedge clk);
        #1;
        acc = cycle;
        startS = 1'b0; startW = 1'b0;
        guard = 0;
        while (!(wide ? doneW : doneS) && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        lat  = cycle - acc;
        gotR = wide ? rW : rS;
        gotC = wide ? coutW : coutS;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] mR;
        logic mC, mZ, mO;
        logic [15:0] sR;
        logic sC;
        int sLat;
        int dB;
        logic [2:0] opPick[8];

        vecs[0] = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{OP_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{OP_OR,  32'h0F0F0F0F, 32'hF0F0F000, 32'hFFFFFF0F, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3'b011, 32'h00000123, 32'h00000456, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{OP_SUB, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};

        opPick = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, 3'b011, 3'b100, 3'b101};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; f = '0;
        startS = 1'b0; startW = 1'b0; aS = '0; bS = '0; fS = '0;

        // Reset state while rst_n is held low.
        #12;
        checkOutput("reset ready", {31'b0, ready}, 32'h1);
        checkOutput("reset done", {31'b0, done}, 32'h0);
        checkOutput("reset r", r, 32'h0);
        checkOutput("reset cout", {31'b0, cout}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            checkOp($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                    vecs[i].expR, vecs[i].expCout, vecs[i].expZero, vecs[i].expOvf);
        end

        for (int i = 0; i < 30; i++) begin
            logic [2:0] op;
            logic [31:0] ra, rb;
            op = opPick[$urandom_range(0, 7)];
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            refAlu(op, ra, rb, mR, mC, mZ, mO);
            checkOp($sformatf("rand%0d f=%0d a=%h b=%h", i, op, ra, rb), op, ra, rb, mR, mC, mZ, mO);
        end

        // Make r non-zero, then reset in the second RUN cycle of an ADD.
        checkOp("preReset", OP_OR, 32'h12345678, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        f = OP_ADD; a = 32'hFFFFFFFF; b = 32'h1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        dB = doneCount;
        #1;
        checkOutput("midReset ready", {31'b0, ready}, 32'h1);
        checkOutput("midReset done", {31'b0, done}, 32'h0);
        checkOutput("midReset r", r, 32'h0);
        checkOutput("midReset cout", {31'b0, cout}, 32'h0);
`ifdef ALU_FLAGS_EN
        checkOutput("midReset zero", {31'b0, zero}, 32'h0);
        checkOutput("midReset ovf", {31'b0, ovf}, 32'h0);
`endif
        repeat (6) @(negedge clk);
        checkOutput("midReset noDone", doneCount - dB, 0);
        rst_n = 1'b1;
        checkOp("postReset add", OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);

        runSmall(1'b0, sR, sC, sLat);
        checkOutput("w16s1 r", {16'h0, sR}, 32'h0);
        checkOutput("w16s1 cout", {31'b0, sC}, 32'h1);
        checkOutput("w16s1 latency", sLat, 16);
        runSmall(1'b1, sR, sC, sLat);
        checkOutput("w16s16 r", {16'h0, sR}, 32'h0);
        checkOutput("w16s16 cout", {31'b0, sC}, 32'h1);
        checkOutput("w16s16 latency", sLat, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
